digit_feature_recognizer: RTL

//  Per-frame stroke-feature digit recogniser (0-9) on the binarised TFT pixel stream; successor to the fixed-ROI recogniser.

---
 rtl/digit_reco_pkg.sv | 26 ++
 rtl/dfr_line_probe.sv | 44 ++++
 rtl/digit_feature_recognizer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/digit_reco_pkg.sv
// digit_reco_pkg: FSM states, signature layout and digit table shared by the recogniser
package digit_reco_pkg;
  typedef enum logic [2:0] {S_WAIT, S_SCAN, S_EVAL, S_GEOM0, S_GEOM1} state_t;
  localparam logic [3:0] DIGIT_UNKNOWN = 4'hF;
  localparam int SIG_X1L = 15;
  localparam int SIG_X1R = 14;
  localparam int SIG_X2L = 13;
  localparam int SIG_X2R = 12;
  localparam int SIG_Y = 8;
  localparam int SIG_X1 = 4;
  localparam int SIG_X2 = 0;
  localparam logic [15:0] DIGIT_SIG [10] = '{
    16'hF222, 16'hA111, 16'h6311, 16'h5311, 16'hD221,
    16'h9311, 16'hB312, 16'h0211, 16'hF322, 16'hD321};
  localparam logic [15:0] DIGIT_MASK [10] = '{
    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
    16'hFFFF, 16'hFFFF, 16'h0FFF, 16'hFFFF, 16'hFFFF};
  // signatures are mutually exclusive, so scan order does not matter
  function automatic logic [3:0] classify(input logic [15:0] s);
    logic [3:0] d;
    d = DIGIT_UNKNOWN;
    for (int i = 0; i < 10; i++)
      if ((s & DIGIT_MASK[i]) == DIGIT_SIG[i]) d = 4'(i);
    return d;
  endfunction
endpackage

// File: rtl/dfr_line_probe.sv
// dfr_line_probe: counts stroke runs along one ROI row and notes which side of the midline they touch
module dfr_line_probe #(
  parameter int HW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          fg,
  input  logic [HW-1:0] row,
  input  logic [HW-1:0] x_l,
  input  logic [HW-1:0] x_r,
  input  logic [HW-1:0] hm,
  input  logic [HW-1:0] hcount,
  input  logic [HW-1:0] vcount,
  output logic [3:0]    cnt,
  output logic          left,
  output logic          right
);
  logic prev, act, inc;
  // a run ends on a fg->bg step inside the ROI, or when it reaches the right edge still in fg
  always_comb begin
    act = en && vcount == row && hcount >= x_l && hcount <= x_r;
    inc = act && (fg ? hcount == x_r : (prev && hcount != x_l));
  end
  // saturating run counter and side flags, cleared once per frame
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev <= 1'b0;
      cnt <= '0;
      left <= 1'b0;
      right <= 1'b0;
    end else if (clr) begin
      prev <= 1'b0;
      cnt <= '0;
      left <= 1'b0;
      right <= 1'b0;
    end else if (act) begin
      prev <= fg;
      cnt <= (inc && cnt != 4'hF) ? cnt + 4'd1 : cnt;
      left <= left | (fg && hcount < hm);
      right <= right | (fg && hcount > hm);
    end
endmodule

// File: rtl/digit_feature_recognizer.sv
// digit_feature_recognizer: per-frame stroke-feature digit recogniser with runtime ROI and stability filter
module digit_feature_recognizer
  import digit_reco_pkg::*;
#(
  parameter int HW = 12,
  parameter int K_X1 = 102,
  parameter int K_X2 = 171,
  parameter int STABLE_N = 3,
  parameter int FG_POL = 1
) (
  input  logic          TFT_VCLK,
  input  logic          rst,
  input  logic          TFT_VS,
  input  logic [HW-1:0] hcount,
  input  logic [HW-1:0] vcount,
  input  logic          th_flag,
  input  logic [HW-1:0] roi_x_l,
  input  logic [HW-1:0] roi_x_r,
  input  logic [HW-1:0] roi_y_t,
  input  logic [HW-1:0] roi_y_b,
  output logic [15:0]   send_str,
  output logic [3:0]    reco_digital,
  output logic          reco_valid,
  output logic          roi_err
);
  localparam logic [3:0] SN = 4'(STABLE_N);
  state_t state, nstate;
  logic vs_d, vs_rise, fg, en, clr, col_act, col_inc, col_prev, same, pub;
  logic [HW-1:0] xl, xr, yt, yb, v1, v2, hm;
  logic [HW+7:0] prod1, prod2;
  logic [3:0] ycnt, x1cnt, x2cnt, run, run_nx, last_cand, cand;
  logic x1l, x1r, x2l, x2r;
  logic [15:0] feat;
  assign vs_rise = TFT_VS & ~vs_d;
  assign fg = th_flag == 1'(FG_POL);
  assign en = state == S_SCAN && !roi_err;
  assign clr = state == S_GEOM1;
  dfr_line_probe #(.HW(HW)) u_row1 (
    .clk(TFT_VCLK), .rst(rst), .clr(clr), .en(en), .fg(fg), .row(v1), .x_l(xl), .x_r(xr),
    .hm(hm), .hcount(hcount), .vcount(vcount), .cnt(x1cnt), .left(x1l), .right(x1r));
  dfr_line_probe #(.HW(HW)) u_row2 (
    .clk(TFT_VCLK), .rst(rst), .clr(clr), .en(en), .fg(fg), .row(v2), .x_l(xl), .x_r(xr),
    .hm(hm), .hcount(hcount), .vcount(vcount), .cnt(x2cnt), .left(x2l), .right(x2r));
  // state register
  always_ff @(posedge TFT_VCLK or posedge rst)
    if (rst) state <= S_WAIT;
    else state <= nstate;
  // frame sequencing; the first frame after reset is only measured, never evaluated
  always_comb begin
    nstate = state;
    case (state)
      S_WAIT: nstate = vs_rise ? S_GEOM0 : S_WAIT;
      S_SCAN: nstate = vs_rise ? S_EVAL : S_SCAN;
      S_EVAL: nstate = S_GEOM0;
      S_GEOM0: nstate = S_GEOM1;
      S_GEOM1: nstate = S_SCAN;
      default: nstate = S_WAIT;
    endcase
  end
  // column probe, signature assembly, classification and stability decision
  always_comb begin
    col_act = en && hcount == hm && vcount >= yt && vcount <= yb;
    col_inc = col_act && (fg ? vcount == yb : col_prev);
    feat = '0;
    feat[SIG_X1L] = x1l;
    feat[SIG_X1R] = x1r;
    feat[SIG_X2L] = x2l;
    feat[SIG_X2R] = x2r;
    feat[SIG_Y +: 4] = ycnt;
    feat[SIG_X1 +: 4] = x1cnt;
    feat[SIG_X2 +: 4] = x2cnt;
    cand = classify(feat);
    same = cand == last_cand;
    run_nx = !same ? 4'd1 : (run == 4'hF ? run : run + 4'd1);
    pub = !roi_err && cand != DIGIT_UNKNOWN && run_nx == SN && !(same && run == SN);
  end
  // geometry pipeline, column counter, filter state and outputs
  always_ff @(posedge TFT_VCLK or posedge rst)
    if (rst) begin
      vs_d <= 1'b0;
      {xl, xr, yt, yb, v1, v2, hm} <= '0;
      {prod1, prod2} <= '0;
      ycnt <= '0;
      col_prev <= 1'b0;
      run <= '0;
      last_cand <= DIGIT_UNKNOWN;
      send_str <= '0;
      reco_digital <= DIGIT_UNKNOWN;
      reco_valid <= 1'b0;
      roi_err <= 1'b0;
    end else begin
      vs_d <= TFT_VS;
      reco_valid <= 1'b0;
      if (state == S_EVAL) begin
        send_str <= feat;
        run <= roi_err ? 4'd0 : run_nx;
        last_cand <= roi_err ? DIGIT_UNKNOWN : cand;
        reco_valid <= pub;
        if (pub) reco_digital <= cand;
      end
      if (state == S_GEOM0) begin
        xl <= roi_x_l;
        xr <= roi_x_r;
        yt <= roi_y_t;
        yb <= roi_y_b;
        roi_err <= roi_x_r <= roi_x_l || roi_y_b <= roi_y_t;
        prod1 <= (HW+8)'(roi_y_b - roi_y_t) * (HW+8)'(K_X1);
        prod2 <= (HW+8)'(roi_y_b - roi_y_t) * (HW+8)'(K_X2);
      end
      if (state == S_GEOM1) begin
        v1 <= HW'((prod1 >> 8) + (HW+8)'(yt));
        v2 <= HW'((prod2 >> 8) + (HW+8)'(yt));
        hm <= HW'(((HW+1)'(xl) + (HW+1)'(xr)) >> 1);
        ycnt <= '0;
        col_prev <= 1'b0;
      end
      if (col_act) begin
        col_prev <= fg;
        ycnt <= (col_inc && ycnt != 4'hF) ? ycnt + 4'd1 : ycnt;
      end
    end
endmodule
